// File: rtl/ahbl_ram_slave.sv
// ahbl_ram_slave: AHB-Lite responder backed by a word-organised RAM with a
// fixed number of wait states per OKAY transfer.
// Build option: define AHBL_RAM_SLAVE_ERR_EN to return two-cycle ERROR
// responses for out-of-range or misaligned transfers; without it, addresses
// wrap and unused low offset bits are ignored.
//
// state | meaning
// IDLE  | no data phase in progress
// WAIT  | inserting wait states, HREADYOUT low
// DATA  | last cycle of an OKAY data phase (write commits, read data driven)
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high
module ahbl_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   offset;
  logic [1:0]    hsize_c;
  logic          accept;
  logic [3:0]    be;
  logic          mem_we;

  assign offset  = HADDR - BASE_ADDR;
  // sizes above word behave as word
  assign hsize_c = (HSIZE > 3'd2) ? 2'd2 : HSIZE[1:0];
  assign accept  = HSEL & HREADY & HTRANS[1];

`ifdef AHBL_RAM_SLAVE_ERR_EN
  logic err_flag;
  logic unused_bits;
  assign unused_bits = HTRANS[0];

  // flag out-of-range (including underflow below base) and misaligned accesses
  always_comb begin
    err_flag = 1'b0;
    if (offset[31:AW+2] != '0) err_flag = 1'b1;
    if (hsize_c == 2'd1 && offset[0]) err_flag = 1'b1;
    if (hsize_c == 2'd2 && offset[1:0] != 2'b00) err_flag = 1'b1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{offset[31:AW+2], HTRANS[0]};
`endif

  // next-state: capture a new address phase whenever the previous data phase is ending
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      WAIT: begin
        if (cnt_q == 4'd0) state_d = DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
`ifdef AHBL_RAM_SLAVE_ERR_EN
      ERR1: state_d = ERR2;
`endif
      default: begin
        state_d = IDLE;
        if (accept) begin
          idx_d   = offset[AW+1:2];
          lane_d  = offset[1:0];
          size_d  = hsize_c;
          write_d = HWRITE;
`ifdef AHBL_RAM_SLAVE_ERR_EN
          if (err_flag) begin
            state_d = ERR1;
          end else
`endif
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = DATA;
          end
        end
      end
    endcase
  end

  // state and captured address-phase registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // little-endian byte lanes; half uses only offset[1]
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be[lane_q] = 1'b1;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign mem_we = (state_q == DATA) & write_q;

  // RAM write at the end of the DATA cycle; contents are never reset
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = (state_q == DATA && !write_q) ? mem_q[idx_q] : 32'h0;

`ifdef AHBL_RAM_SLAVE_ERR_EN
  assign HREADYOUT = !(state_q == WAIT || state_q == ERR1);
  assign HRESP     = (state_q == ERR1) || (state_q == ERR2);
`else
  assign HREADYOUT = (state_q != WAIT);
  assign HRESP     = 1'b0;
`endif

endmodule
